// File: rtl/prince_pkg.sv
// Shared PRINCE primitives: round constants, S-box layers, M'/SR linear layers, FSM state type.
`default_nettype none

package prince_pkg;

  localparam logic [63:0] PRINCE_ALPHA = 64'hC0AC29B7C97C50DD;

  // Nibble x of the table sits at bits [4x+3:4x]
  localparam logic [63:0] SBOX_TBL     = 64'h4D5E087619CA23FB;
  localparam logic [63:0] SBOX_INV_TBL = 64'h1CE5046A98DF237B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] rc(input logic [3:0] idx);
    logic [63:0] r;
    case (idx)
      4'd0:    r = 64'h0000000000000000;
      4'd1:    r = 64'h13198a2e03707344;
      4'd2:    r = 64'ha4093822299f31d0;
      4'd3:    r = 64'h082efa98ec4e6c89;
      4'd4:    r = 64'h452821e638d01377;
      4'd5:    r = 64'hbe5466cf34e90c6c;
      4'd6:    r = 64'h7ef84f78fd955cb1;
      4'd7:    r = 64'h85840851f1ac43aa;
      4'd8:    r = 64'hc882d32f25323c54;
      4'd9:    r = 64'h64a51195e0e3610d;
      4'd10:   r = 64'hd3b5a399ca0c2399;
      4'd11:   r = 64'hc0ac29b7c97c50dd;
      default: r = 64'h0000000000000000;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
    logic [63:0] tbl;
    logic [63:0] y;
    tbl = inv ? SBOX_INV_TBL : SBOX_TBL;
    y   = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = tbl[{x[4*i +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  // 16-bit block of M'; nibbles and bits numbered from the MSB. Output bit b of
  // nibble j is the XOR of bit b of every input nibble except one.
  function automatic logic [15:0] m_hat(input logic [15:0] x, input logic sel);
    logic [15:0] y;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 4; i++) begin
          if (i != ((b - j - int'(sel)) & 3)) begin
            y[15-(4*j+b)] = y[15-(4*j+b)] ^ x[15-(4*i+b)];
          end
        end
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] m_prime(input logic [63:0] x);
    return {m_hat(x[63:48], 1'b0), m_hat(x[47:32], 1'b1),
            m_hat(x[31:16], 1'b1), m_hat(x[15:0], 1'b0)};
  endfunction

  function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int src;
    y = '0;
    for (int k = 0; k < 16; k++) begin
      src = inv ? ((k - 4*(k % 4)) & 15) : ((k + 4*(k % 4)) & 15);
      y[63-4*k -: 4] = x[63-4*src -: 4];
    end
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prince_round_dp.sv
// Combinational PRINCE round: forward (rnd 1..5), middle (rnd 6), inverse (rnd 7..11).
`default_nettype none

module prince_round_dp
  import prince_pkg::*;
(
  input  logic [63:0] s,
  input  logic [63:0] kd,
  input  logic [3:0]  rnd,
  output logic [63:0] s_next
);

  logic [63:0] sb;
  logic [63:0] mp;
  logic [63:0] fwd;
  logic [63:0] mid;
  logic [63:0] inv;

  always_comb begin
    sb  = s_layer(s, 1'b0);
    mp  = m_prime(sb);
    fwd = shift_rows(mp, 1'b0) ^ rc(rnd) ^ kd;
    mid = s_layer(mp, 1'b1);
    // M^-1 = M' after SR^-1, since M = SR after M'
    inv = s_layer(m_prime(shift_rows(s ^ kd ^ rc(rnd - 4'd1), 1'b1)), 1'b1);
    if (rnd <= 4'd5) begin
      s_next = fwd;
    end else if (rnd == 4'd6) begin
      s_next = mid;
    end else begin
      s_next = inv;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prince_dec_top.sv
// Round-iterative PRINCE decryption via alpha-reflection; one round per clock.
// PRINCE_DEC_ENC_MODE_EN adds a 'mode' input (1 = encrypt, 0 = decrypt).
`default_nettype none

module prince_dec_top
  import prince_pkg::*;
#(
  parameter logic [63:0] ALPHA = PRINCE_ALPHA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  ciphertext,
  input  logic [127:0] key,
`ifdef PRINCE_DEC_ENC_MODE_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  plaintext,
  output logic         busy
);

  state_t      state, state_nxt;
  logic [63:0] s;
  logic [63:0] kd;
  logic [63:0] k_out;
  logic [3:0]  rnd;
  logic [63:0] k0, k1, k0p;
  logic [63:0] k_in_nxt, k_out_nxt, kd_nxt;
  logic [63:0] s_round;
  logic        accept;
  logic        last;

  assign k0  = key[127:64];
  assign k1  = key[63:0];
  assign k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};

`ifdef PRINCE_DEC_ENC_MODE_EN
  assign k_in_nxt  = mode ? k0  : k0p;
  assign k_out_nxt = mode ? k0p : k0;
  assign kd_nxt    = mode ? k1  : (k1 ^ ALPHA);
`else
  assign k_in_nxt  = k0p;
  assign k_out_nxt = k0;
  assign kd_nxt    = k1 ^ ALPHA;
`endif

  assign accept = (state == ST_IDLE) && in_valid;
  assign last   = (state == ST_RUN) && (rnd == 4'd11);

  prince_round_dp u_round (
    .s      (s),
    .kd     (kd),
    .rnd    (rnd),
    .s_next (s_round)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (rnd == 4'd11) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      rnd       <= '0;
      kd        <= '0;
      k_out     <= '0;
      plaintext <= '0;
    end else if (accept) begin
      s     <= ciphertext ^ k_in_nxt ^ kd_nxt ^ rc(4'd0);
      rnd   <= 4'd1;
      kd    <= kd_nxt;
      k_out <= k_out_nxt;
    end else if (state == ST_RUN) begin
      s   <= s_round;
      rnd <= rnd + 4'd1;
      if (last) plaintext <= s_round ^ rc(4'd11) ^ kd ^ k_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prince_dec_top.sv
// Self-checking bench for prince_dec_top: known-answer table plus handshake corner cases.
`timescale 1ns/1ps
`default_nettype none

module tb_prince_dec_top;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  plaintext;
  logic         busy;
`ifdef PRINCE_DEC_ENC_MODE_EN
  logic         mode;
`endif

  always #5 clk = ~clk;

  prince_dec_top dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
`ifdef PRINCE_DEC_ENC_MODE_EN
    .mode       (mode),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  typedef struct {
    logic [63:0]  ct;
    logic [127:0] key;
    logic         mode;
    logic [63:0]  exp;
    int           hold;
  } vec_t;

  vec_t        vecs[7];
  int          nvec;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_edge = 0;
  logic [63:0] cur_exp;
  logic [63:0] exp_q[$];
  logic        ov_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accepted request, pop on accepted result
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_edge = cyc + 1;
      end
      if (out_valid && !ov_prev) check("latency", 64'(cyc - acc_edge), 64'd11);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else check("plaintext", plaintext, exp_q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  task automatic drive(input vec_t v);
    ciphertext = v.ct;
    key        = v.key;
    cur_exp    = v.exp;
`ifdef PRINCE_DEC_ENC_MODE_EN
    mode       = v.mode;
`endif
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ciphertext = {$urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
    wait_out("out_valid_timeout");
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_plaintext", plaintext, v.exp);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ov_seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    cur_exp    = '0;
`ifdef PRINCE_DEC_ENC_MODE_EN
    mode       = 1'b0;
`endif
    vecs[0] = '{64'h818665aa0d02dfda, 128'h0, 1'b0, 64'h0000000000000000, 0};
    vecs[1] = '{64'h604ae6ca03c20ada, 128'h0, 1'b0, 64'hffffffffffffffff, 0};
    vecs[2] = '{64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'h0}, 1'b0, 64'h0, 0};
    vecs[3] = '{64'h78a54cbe737bb7ef, {64'h0, 64'hffffffffffffffff}, 1'b0, 64'h0, 0};
    vecs[4] = '{64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 1'b0, 64'h0123456789abcdef, 5};
    vecs[5] = '{64'h0000000000000000, 128'h0, 1'b1, 64'h818665aa0d02dfda, 0};
    vecs[6] = '{64'h0123456789abcdef, {64'h0, 64'hfedcba9876543210}, 1'b1, 64'hae25ad3ca8fa9ccf, 0};
`ifdef PRINCE_DEC_ENC_MODE_EN
    nvec = 7;
`else
    nvec = 5;
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_plaintext", plaintext, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // Back-to-back: in_valid held high, second block waits for DONE->IDLE
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(vecs[1]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    check("b2b_accept_spacing", 64'(n), 64'd13);
    check("b2b_busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("b2b_out_valid_timeout");
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Abort during the middle round
    @(posedge clk); #1;
    drive(vecs[2]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_plaintext", plaintext, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ov_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("abort_no_output", 64'(ov_seen), 64'd0);
    check("abort_idle_ready", 64'(in_ready), 64'd1);

    run_vec(vecs[3]);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
